// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the mantissa normalization unit.
// Holds the FSM encoding and the default datapath widths.
package fpu_norm_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;
    localparam int NIB_CNT    = MANT_W_DEF / 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_DONE   = 2'd3
    } norm_state_t;

endpackage

// File: rtl/nibble_lz_count.sv
// Counts the leading all-zero nibbles of a mantissa.
// This count sets the coarse 4-bit-step shift amount.
module nibble_lz_count
    import fpu_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic [MANT_W-1:0] mant,
    output logic [2:0]        count
);

    localparam int NIBS = MANT_W / 4;

    logic [NIBS-1:0] nib_zero;
    logic            found;

    always_comb begin
        for (int i = 0; i < NIBS; i++) begin
            nib_zero[i] = (mant[4*i +: 4] == 4'h0);
        end
    end

    // Scan from the most significant nibble and stop counting at the first nonzero one.
    always_comb begin
        count = 3'd0;
        found = 1'b0;
        for (int i = NIBS - 1; i >= 0; i--) begin
            if (!found) begin
                if (nib_zero[i]) begin
                    count = count + 3'd1;
                end else begin
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/norm_shift_unit.sv
// Multi-cycle normalizer: a coarse nibble shift, then single-bit fine shifts.
// The exponent stops at zero, and the result is flagged denormal when it does.
module norm_shift_unit
    import fpu_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic [4:0]        out_shift,
    output logic              out_zero,
    output logic              out_denorm
);

    norm_state_t       state, state_n;
    logic              sign_r, sign_n;
    logic [EXP_W-1:0]  exp_r, exp_n;
    logic [MANT_W-1:0] mant_r, mant_n;
    logic [4:0]        shift_r, shift_n;
    logic              zero_r, zero_n;
    logic              denorm_r, denorm_n;

    logic [2:0]        lz_nib;
    logic [4:0]        coarse_s;

    nibble_lz_count #(.MANT_W(MANT_W)) u_lz (
        .mant  (mant_r),
        .count (lz_nib)
    );

    assign coarse_s = {lz_nib, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= '0;
            shift_r  <= 5'd0;
            zero_r   <= 1'b0;
            denorm_r <= 1'b0;
        end else begin
            state    <= state_n;
            sign_r   <= sign_n;
            exp_r    <= exp_n;
            mant_r   <= mant_n;
            shift_r  <= shift_n;
            zero_r   <= zero_n;
            denorm_r <= denorm_n;
        end
    end

    always_comb begin
        state_n  = state;
        sign_n   = sign_r;
        exp_n    = exp_r;
        mant_n   = mant_r;
        shift_n  = shift_r;
        zero_n   = zero_r;
        denorm_n = denorm_r;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_n   = in_sign;
                    exp_n    = in_exp;
                    mant_n   = in_mant;
                    shift_n  = 5'd0;
                    zero_n   = 1'b0;
                    denorm_n = 1'b0;
                    state_n  = ST_COARSE;
                end
            end
            ST_COARSE: begin
                if (mant_r == '0) begin
                    exp_n   = '0;
                    zero_n  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    // The coarse step is skipped entirely when it would underflow the exponent.
                    if (int'(exp_r) > int'(coarse_s)) begin
                        mant_n  = mant_r << coarse_s;
                        exp_n   = exp_r - EXP_W'(coarse_s);
                        shift_n = coarse_s;
                    end
                    state_n = ST_FINE;
                end
            end
            ST_FINE: begin
                if (mant_r[MANT_W-1]) begin
                    denorm_n = (exp_r == '0);
                    state_n  = ST_DONE;
                end else if (exp_r <= EXP_W'(1)) begin
                    exp_n    = '0;
                    denorm_n = 1'b1;
                    state_n  = ST_DONE;
                end else begin
                    mant_n  = mant_r << 1;
                    exp_n   = exp_r - EXP_W'(1);
                    shift_n = shift_r + 5'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign out_sign   = sign_r;
    assign out_exp    = exp_r;
    assign out_mant   = mant_r;
    assign out_shift  = shift_r;
    assign out_zero   = zero_r;
    assign out_denorm = denorm_r;

endmodule

// File: tb/tb_norm_shift_unit.sv
// Self-checking bench for norm_shift_unit using an expected-result queue.
// Directed corner operands, random operands, a back-pressure stall and a mid-operation reset.
module tb_norm_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic        out_valid, out_ready, out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic [4:0]  out_shift;
    logic        out_zero, out_denorm;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic [4:0]  shift;
        logic        zero;
        logic        denorm;
        int          lat;
    } expect_t;

    expect_t sbQ[$];
    int      nChecks = 0;
    int      nFail = 0;
    int      cyc = 0;
    int      acceptCyc = 0;

    norm_shift_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_shift  (out_shift),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference normalization: nibble skip guarded by the exponent, then bit steps.
    function automatic expect_t model(input logic s, input logic [7:0] e, input logic [23:0] m);
        expect_t r;
        int      z, ex, sh;
        logic    stop;
        logic [23:0] mm;
        r.sign = s; r.zero = 1'b0; r.denorm = 1'b0;
        if (m == 24'h0) begin
            r.exp = 8'h0; r.mant = 24'h0; r.shift = 5'd0; r.zero = 1'b1; r.lat = 2;
            return r;
        end
        z = 0; stop = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (!stop && ((m >> (4*i)) & 24'hF) == 24'h0) z++;
            else stop = 1'b1;
        end
        mm = m; ex = int'(e); sh = 0; r.lat = 3;
        if (ex > 4*z) begin
            mm = m << (4*z); ex = ex - 4*z; sh = 4*z;
        end
        stop = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (!stop) begin
                if (mm[23]) begin
                    r.denorm = (ex == 0); stop = 1'b1;
                end else if (ex <= 1) begin
                    ex = 0; r.denorm = 1'b1; stop = 1'b1;
                end else begin
                    mm = mm << 1; ex--; sh++; r.lat++;
                end
            end
        end
        r.exp = 8'(ex); r.mant = mm; r.shift = 5'(sh);
        return r;
    endfunction

    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [23:0] m);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        acceptCyc = cyc;
        sbQ.push_back(model(s, e, m));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input int hold);
        int      n = 0;
        expect_t x;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checkOutput("result_timeout", 32'd0, 32'd1);
            if (sbQ.size() > 0) void'(sbQ.pop_front());
            return;
        end
        if (sbQ.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
            return;
        end
        x = sbQ.pop_front();
        checkOutput("sign",    32'(out_sign),   32'(x.sign));
        checkOutput("exp",     32'(out_exp),    32'(x.exp));
        checkOutput("mant",    32'(out_mant),   32'(x.mant));
        checkOutput("shift",   32'(out_shift),  32'(x.shift));
        checkOutput("zero",    32'(out_zero),   32'(x.zero));
        checkOutput("denorm",  32'(out_denorm), 32'(x.denorm));
        checkOutput("latency", 32'(cyc - acceptCyc), 32'(x.lat));
        checkOutput("busy_in_done", 32'(in_ready), 32'd0);
        // A competing operand is offered during the stall and must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_sign = ~x.sign; in_exp = 8'hA5; in_mant = ~x.mant;
            @(negedge clk);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_ready", 32'(in_ready),  32'd0);
            checkOutput("stall_mant",  32'(out_mant),  32'(x.mant));
            checkOutput("stall_exp",   32'(out_exp),   32'(x.exp));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_hs_valid", 32'(out_valid), 32'd0);
        checkOutput("post_hs_ready", 32'(in_ready),  32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_outs"},
                    {out_sign, out_exp, out_mant[22:0]} | 32'(out_mant[23]) | 32'(out_shift)
                    | 32'(out_zero) | 32'(out_denorm), 32'd0);
    endtask

    initial begin
        logic saw;
        logic [23:0] rm;
        rst = 1'b1; in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h55; in_mant = 24'hFFFFFF;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0; in_valid = 1'b0;

        applyStimulus(1'b0, 8'd100, 24'h800000); waitResult(0);
        applyStimulus(1'b0, 8'd100, 24'h000001); waitResult(0);
        applyStimulus(1'b1, 8'd50,  24'h000000); waitResult(0);
        applyStimulus(1'b0, 8'd3,   24'h000100); waitResult(0);
        applyStimulus(1'b1, 8'd0,   24'h123456); waitResult(0);
        applyStimulus(1'b0, 8'd0,   24'h800000); waitResult(0);
        applyStimulus(1'b0, 8'd1,   24'h000010); waitResult(0);
        applyStimulus(1'b1, 8'd200, 24'h00F000); waitResult(5);
        applyStimulus(1'b0, 8'd20,  24'h000003); waitResult(0);

        for (int i = 0; i < 10; i++) begin
            rm = 24'($urandom) >> $urandom_range(0, 23);
            applyStimulus(1'($urandom), 8'($urandom_range(0, 255)), rm);
            waitResult(0);
        end

        // Abort an operand while it is still shifting.
        applyStimulus(1'b1, 8'd100, 24'h000001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("midrst");
        sbQ.delete();
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        checkOutput("midrst_no_valid", 32'(saw), 32'd0);

        applyStimulus(1'b0, 8'd10, 24'h400000); waitResult(0);
        checkOutput("queue_empty", 32'(sbQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
